// File: rtl/btn_step_decoder.sv
// Pushbutton front end: synchronise, debounce, then turn presses into one-cycle step pulses.
// Define BTN_REPEAT_EN to emit auto-repeat pulses while the button is in long-hold.
module btn_step_decoder #(
  parameter int unsigned DEBOUNCE_CYC = 240000,
  parameter int unsigned LONG_CYC     = 12000000,
  parameter int unsigned REPEAT_CYC   = 2400000
) (
  input  logic       x1,
  input  logic       reset,
  input  logic       btn_n,
  output logic       btn_state,
  output logic       inc_pulse,
  output logic       long_hold,
  output logic [7:0] press_cnt
);

  localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HoldW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StPressed, StHold} state_e;

  state_e             state_q;
  logic [1:0]         sync_q;
  logic               s_btn_q;
  logic [DbW-1:0]     db_cnt_q;
  logic [HoldW-1:0]   hold_cnt_q;
  logic               btn_state_q;
  logic               inc_pulse_q;
  logic               long_hold_q;
  logic [7:0]         press_cnt_q;

  logic db_hit;
  logic btn_rise;
  logic btn_fall;
  logic long_hit;

`ifdef BTN_REPEAT_EN
  localparam int unsigned RepW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  logic [RepW-1:0] rep_cnt_q;
  logic            rep_hit;
  assign rep_hit = (rep_cnt_q == RepW'(REPEAT_CYC - 1));
`endif

  // The FSM reacts to the debounce decision itself, so the first pulse lands
  // on the same edge as the btn_state rise.
  always_comb begin
    db_hit   = (s_btn_q != btn_state_q) && (db_cnt_q == DbW'(DEBOUNCE_CYC - 1));
    btn_rise = db_hit && !btn_state_q;
    btn_fall = db_hit && btn_state_q;
    long_hit = (hold_cnt_q == HoldW'(LONG_CYC - 1));
  end

  always_ff @(posedge x1) begin
    if (reset) begin
      sync_q      <= 2'b11;
      s_btn_q     <= 1'b0;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      btn_state_q <= 1'b0;
      inc_pulse_q <= 1'b0;
      long_hold_q <= 1'b0;
      press_cnt_q <= '0;
      state_q     <= StIdle;
`ifdef BTN_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      s_btn_q <= ~sync_q[1];

      if (s_btn_q == btn_state_q) begin
        db_cnt_q <= '0;
      end else if (db_hit) begin
        db_cnt_q    <= '0;
        btn_state_q <= ~btn_state_q;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end

      press_cnt_q <= press_cnt_q + {7'd0, inc_pulse_q};
      inc_pulse_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (btn_rise) begin
            inc_pulse_q <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= StPressed;
          end
        end
        StPressed: begin
          if (btn_fall) begin
            state_q <= StIdle;
          end else if (long_hit) begin
            long_hold_q <= 1'b1;
            state_q     <= StHold;
`ifdef BTN_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StHold: begin
          // Release takes priority over a coincident repeat terminal count.
          if (btn_fall) begin
            long_hold_q <= 1'b0;
            state_q     <= StIdle;
          end
`ifdef BTN_REPEAT_EN
          else if (rep_hit) begin
            inc_pulse_q <= 1'b1;
            rep_cnt_q   <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + RepW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign btn_state = btn_state_q;
  assign inc_pulse = inc_pulse_q;
  assign long_hold = long_hold_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_btn_step_decoder.sv
// Bench for btn_step_decoder: directed scenarios plus random bouncy input, all outputs
// compared every cycle against an edge-indexed reference model.
module tb_btn_step_decoder;

  localparam int Db = 4;
  localparam int Lg = 20;
  localparam int Rp = 5;
`ifdef BTN_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  logic       x1 = 1'b0;
  logic       reset = 1'b1;
  logic       btn_n = 1'b1;
  logic       btn_state;
  logic       inc_pulse;
  logic       long_hold;
  logic [7:0] press_cnt;

  int n_checks = 0;
  int n_err    = 0;

  btn_step_decoder #(
    .DEBOUNCE_CYC(Db),
    .LONG_CYC    (Lg),
    .REPEAT_CYC  (Rp)
  ) dut (
    .x1       (x1),
    .reset    (reset),
    .btn_n    (btn_n),
    .btn_state(btn_state),
    .inc_pulse(inc_pulse),
    .long_hold(long_hold),
    .press_cnt(press_cnt)
  );

  always #5 x1 = ~x1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model, indexed by absolute rising-edge number k.
  logic       smp [64];
  int         k          = 0;
  int         last_rst   = 0;
  int         last_tog   = 0;
  int         press_edge = -1;
  logic       m_state    = 1'b0;
  logic       m_pulse    = 1'b0;
  logic       m_long     = 1'b0;
  logic [7:0] m_cnt      = 8'd0;

  // Active-high level visible to the debouncer after edge j.
  function automatic logic vis(input int j);
    if (j - 2 > last_rst) return ~smp[(j - 2) % 64];
    return 1'b0;
  endfunction

  always @(posedge x1) begin : model
    logic acc;
    logic rise;
    logic fall;
    smp[k % 64] = btn_n;
    if (reset) begin
      last_rst   = k;
      last_tog   = k;
      press_edge = -1;
      m_state    = 1'b0;
      m_pulse    = 1'b0;
      m_long     = 1'b0;
      m_cnt      = 8'd0;
    end else begin
      m_cnt = m_cnt + {7'd0, m_pulse};
      acc   = (k - Db >= last_tog);
      if (acc) begin
        for (int j = k - Db; j < k; j++) if (vis(j) == m_state) acc = 1'b0;
      end
      rise = 1'b0;
      fall = 1'b0;
      if (acc) begin
        m_state  = ~m_state;
        last_tog = k;
        rise     = m_state;
        fall     = ~m_state;
      end
      m_pulse = 1'b0;
      if (rise) begin
        m_pulse    = 1'b1;
        press_edge = k;
      end else if (fall) begin
        press_edge = -1;
        m_long     = 1'b0;
      end else if (press_edge >= 0) begin
        if (k == press_edge + Lg) m_long = 1'b1;
        else if (m_long && RepOn && ((k - press_edge - Lg) % Rp == 0)) m_pulse = 1'b1;
      end
    end
    k++;
  end

  int cyc         = 0;
  int n_pulse     = 0;
  int first_pulse = -1;
  int first_long  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observe on the falling edge, then drive the inputs for the next rising edge.
  task automatic step(input logic b, input logic r);
    @(negedge x1);
    cyc++;
    check("btn_state", {31'd0, btn_state}, {31'd0, m_state});
    check("inc_pulse", {31'd0, inc_pulse}, {31'd0, m_pulse});
    check("long_hold", {31'd0, long_hold}, {31'd0, m_long});
    check("press_cnt", {24'd0, press_cnt}, {24'd0, m_cnt});
    if (inc_pulse === 1'b1) begin
      n_pulse++;
      if (first_pulse < 0) first_pulse = cyc;
    end
    if (long_hold === 1'b1 && first_long < 0) first_long = cyc;
    btn_n = b;
    reset = r;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) step(b, 1'b0);
  endtask

  task automatic clear_stats();
    n_pulse     = 0;
    first_pulse = -1;
    first_long  = -1;
  endtask

  task automatic do_reset(input logic b);
    step(b, 1'b1);
    step(b, 1'b0);
    clear_stats();
  endtask

  initial begin : stim
    int   d;
    int   len;
    logic lvl;

    do_reset(1'b1);
    check("rst_btn_state", {31'd0, btn_state}, 32'd0);
    check("rst_long_hold", {31'd0, long_hold}, 32'd0);
    check("rst_press_cnt", {24'd0, press_cnt}, 32'd0);

    // Clean press: pulse and btn_state on edge Db+2, seen one step after the driving step.
    d = cyc + 1;
    hold(1'b0, 12);
    hold(1'b1, 12);
    check("clean_latency", first_pulse - d, Db + 3);
    check("clean_pulses", n_pulse, 1);
    check("clean_cnt", {24'd0, press_cnt}, 32'd1);

    // Bounce shorter than the debounce window.
    do_reset(1'b1);
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 12);
    check("bounce_pulses", n_pulse, 0);
    check("bounce_cnt", {24'd0, press_cnt}, 32'd0);

    // 40-cycle hold: long-hold after Lg cycles, repeats only when enabled.
    do_reset(1'b1);
    hold(1'b0, 40);
    hold(1'b1, 20);
    check("long_delay", first_long - first_pulse, Lg);
    check("long_pulses", n_pulse, RepOn ? 4 : 1);
    check("long_cnt", {24'd0, press_cnt}, RepOn ? 32'd4 : 32'd1);
    check("long_released", {31'd0, long_hold}, 32'd0);

    // Reset while in long-hold with the button still down.
    do_reset(1'b1);
    hold(1'b0, 30);
    check("pre_rst_long", {31'd0, long_hold}, 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("midrst_btn_state", {31'd0, btn_state}, 32'd0);
    check("midrst_pulse", {31'd0, inc_pulse}, 32'd0);
    check("midrst_long", {31'd0, long_hold}, 32'd0);
    check("midrst_cnt", {24'd0, press_cnt}, 32'd0);
    clear_stats();
    d = cyc;
    hold(1'b0, 20);
    hold(1'b1, 10);
    check("midrst_latency", first_pulse - d, Db + 3);
    check("midrst_pulses", n_pulse, 1);
    check("midrst_cnt_after", {24'd0, press_cnt}, 32'd1);

    // Counter wrap.
    do_reset(1'b1);
    repeat (256) begin
      hold(1'b0, 8);
      hold(1'b1, 8);
    end
    check("wrap_pulses", n_pulse, 256);
    check("wrap_cnt", {24'd0, press_cnt}, 32'd0);
    hold(1'b0, 8);
    hold(1'b1, 8);
    check("wrap_cnt_257", {24'd0, press_cnt}, 32'd1);

    // Random bouncy activity with occasional resets; model checks every cycle.
    do_reset(1'b1);
    repeat (400) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60))
                                        : int'($urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) step(lvl, 1'b1);
      hold(lvl, len);
    end
    hold(1'b1, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
